// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and default geometry for the multiword add/sub sequencer.
package adder_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} add_seq_state_t;
   localparam int unsigned DEF_W = 8;
   localparam int unsigned DEF_K = 4;
endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Operand request and result response handshakes of the sequencer.
interface multiword_add_sequencer_if #(
   parameter int unsigned W = 8,
   parameter int unsigned K = 4
);
   logic           in_valid;
   logic           in_ready;
   logic [W*K-1:0] a;
   logic [W*K-1:0] b;
   logic           cin;
   logic           sub;
   logic           out_valid;
   logic           out_ready;
   logic [W*K-1:0] sum;
   logic           cout;
   logic           ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/multiword_add_sequencer_adder.sv
// N-bit ripple-carry adder slice, one full adder per bit.
module nbits_ripple_adder #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_i,
   output logic [N-1:0] s_o,
   output logic         c_o
);
   logic [N:0] c;

   assign c[0] = c_i;
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end
   assign c_o = c[N];
endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/sub built from one W-bit slice stepped LSB-first over K cycles,
// with the inter-slice carry held in carry_q.
module multiword_add_sequencer
   import adder_ctrl_pkg::*;
#(
   parameter int unsigned W = DEF_W,
   parameter int unsigned K = DEF_K
) (
   input logic                     clk,
   input logic                     rst_n,
   multiword_add_sequencer_if.slave bus
);
   localparam int unsigned IW  = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned MSB = W*K - 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

   add_seq_state_t state_q;
   logic [IW-1:0]  idx_q;
   logic           carry_q;
   logic [MSB:0]   a_q, b_q, sum_q;

   logic [31:0]    base;
   logic [W-1:0]   slice_s;
   logic           slice_co;

   assign base = 32'(idx_q) * 32'(W);

   nbits_ripple_adder #(.N(W)) u_slice (
      .a_i (a_q[base +: W]),
      .b_i (b_q[base +: W]),
      .c_i (carry_q),
      .s_o (slice_s),
      .c_o (slice_co)
   );

   // Subtraction is a + ~b + 1: invert b on capture and seed the carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.in_valid) begin
               a_q     <= bus.a;
               b_q     <= bus.sub ? ~bus.b : bus.b;
               carry_q <= bus.sub ? 1'b1 : bus.cin;
               idx_q   <= '0;
               state_q <= RUN;
            end
            RUN: begin
               sum_q[base +: W] <= slice_s;
               carry_q          <= slice_co;
               if (idx_q == IDX_LAST) state_q <= DONE;
               else                   idx_q   <= idx_q + 1'b1;
            end
            DONE: if (bus.out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = carry_q;
   assign bus.ovf       = (a_q[MSB] == b_q[MSB]) && (sum_q[MSB] != a_q[MSB]);
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed and random checks of the sequencer (W=8,K=4 and W=8,K=1).
module tb_multiword_add_sequencer;
   localparam int unsigned W = 8;
   localparam int unsigned K = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   multiword_add_sequencer_if #(.W(W), .K(K)) bus4 ();
   multiword_add_sequencer_if #(.W(W), .K(1)) bus1 ();

   multiword_add_sequencer #(.W(W), .K(K)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
   multiword_add_sequencer #(.W(W), .K(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the full-width operands.
   task automatic ref_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic sb, output logic [31:0] s, output logic co, output logic ov);
      longint ua, ub, sa, sbv, r, u;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (sb) begin
         u  = ua - ub;
         co = (a >= b);
         r  = sa - sbv;
      end else begin
         u  = ua + ub + longint'(ci);
         co = u[32];
         r  = sa + sbv + longint'(ci);
      end
      s  = u[31:0];
      ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endtask

   // One K=4 op: junk in_valid during RUN/DONE, `hold` cycles of backpressure.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb, input int hold);
      logic [31:0] es, s0;
      logic        ec, eo;
      int          lat;
      ref_op(a, b, ci, sb, es, ec, eo);
      chk({tag, ".in_ready"}, 64'(bus4.in_ready), 64'd1);
      bus4.a = a; bus4.b = b; bus4.cin = ci; bus4.sub = sb; bus4.in_valid = 1'b1;
      tick();
      bus4.a = $urandom; bus4.b = $urandom; bus4.cin = 1'($urandom); bus4.sub = 1'($urandom);
      lat = 0;
      while (!bus4.out_valid && lat < 20) begin
         chk({tag, ".busy"}, 64'(bus4.in_ready), 64'd0);
         tick();
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), 64'(K));
      s0 = bus4.sum;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, ".hold_valid"}, 64'(bus4.out_valid), 64'd1);
         chk({tag, ".hold_sum"}, 64'(bus4.sum), 64'(s0));
         chk({tag, ".hold_ready"}, 64'(bus4.in_ready), 64'd0);
      end
      chk({tag, ".sum"}, 64'(bus4.sum), 64'(es));
      chk({tag, ".cout"}, 64'(bus4.cout), 64'(ec));
      chk({tag, ".ovf"}, 64'(bus4.ovf), 64'(eo));
      bus4.in_valid = 1'b0;
      bus4.out_ready = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
      chk({tag, ".post_valid"}, 64'(bus4.out_valid), 64'd0);
      chk({tag, ".post_ready"}, 64'(bus4.in_ready), 64'd1);
   endtask

   initial begin
      int lat;
      bus4.in_valid = 0; bus4.a = '0; bus4.b = '0; bus4.cin = 0; bus4.sub = 0; bus4.out_ready = 0;
      bus1.in_valid = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0; bus1.sub = 0; bus1.out_ready = 0;

      #2;
      chk("rst.in_ready", 64'(bus4.in_ready), 64'd1);
      chk("rst.out_valid", 64'(bus4.out_valid), 64'd0);
      chk("rst.sum", 64'(bus4.sum), 64'd0);
      chk("rst.cout_ovf", 64'({bus4.cout, bus4.ovf}), 64'd0);
      #10 rst_n = 1'b1;
      tick();

      run_op("carry1",   32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
      run_op("ripple",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
      run_op("borrow",   32'd5,        32'd7,        1'b0, 1'b1, 1);
      run_op("subovf",   32'h80000000, 32'h00000001, 1'b0, 1'b1, 0);
      run_op("addovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
      run_op("backpr",   32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 3);
      run_op("subcin",   32'h00000010, 32'h00000003, 1'b1, 1'b1, 0);

      for (int n = 0; n < 24; n++)
         run_op("rand", $urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

      // Reset while idx==2: everything clears at once and no stale result follows.
      bus4.a = 32'hDEADBEEF; bus4.b = 32'h01020304; bus4.sub = 1'b0; bus4.cin = 1'b1;
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", 64'(bus4.out_valid), 64'd0);
      chk("midrst.sum", 64'(bus4.sum), 64'd0);
      chk("midrst.cout_ovf", 64'({bus4.cout, bus4.ovf}), 64'd0);
      chk("midrst.in_ready", 64'(bus4.in_ready), 64'd1);
      #13 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("postrst.no_valid", 64'(bus4.out_valid), 64'd0);
      end
      run_op("postrst", 32'd1, 32'd2, 1'b0, 1'b0, 0);

      // K=1 instance
      chk("k1.in_ready", 64'(bus1.in_ready), 64'd1);
      bus1.a = 8'hFF; bus1.b = 8'h01; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      lat = 0;
      while (!bus1.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("k1.latency", 64'(lat), 64'd1);
      chk("k1.sum", 64'(bus1.sum), 64'h00);
      chk("k1.cout", 64'(bus1.cout), 64'd1);
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      chk("k1.post_ready", 64'(bus1.in_ready), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
